wshb_frame_reader: RTL and testbench

WSHB_FRAME_READER -- requirements
Module: wshb_frame_reader

---
 rtl/wshb_frame_reader_pkg.sv | 15 +
 rtl/wshb_frame_reader_if.sv | 30 +++
 rtl/wshb_frame_reader_fifo.sv | 59 +++++
 rtl/wshb_frame_reader.sv | 112 +++++++++++
 tb/tb_wshb_frame_reader.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/wshb_frame_reader_pkg.sv
// Shared types for the Wishbone frame-buffer reader.
// FSM states, pixel type and bus word geometry.
package wshb_frame_reader_pkg;

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  typedef logic [23:0] pixel_t;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned FIFO_W = 25;

endpackage

// File: rtl/wshb_frame_reader_if.sv
// Classic Wishbone bus bundle between the frame reader
// (master) and the SDRAM controller (slave).
interface wshb_frame_reader_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output cyc, stb, we, adr, sel,
    output cti, bte, dat_ms,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  cyc, stb, we, adr, sel,
    input  cti, bte, dat_ms,
    output dat_sm, ack, err, rty
  );

endinterface

// File: rtl/wshb_frame_reader_fifo.sv
// First-word-fall-through synchronous FIFO holding
// {sof, pixel} entries for the display side.
module sync_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // a pop frees the slot, so push-on-full is fine then
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/wshb_frame_reader.sv
// Fetches frames word by word over Wishbone and streams
// 24-bit pixels with a start-of-frame marker.
module wshb_frame_reader
  import wshb_frame_reader_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
  parameter int          HDISP      = 800,
  parameter int          VDISP      = 480,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                frame_en,
  wshb_frame_reader_if.master wshb,
  output pixel_t              pix_data,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic                pix_sof
);

  localparam int NPIX = HDISP * VDISP;
  localparam int CW   = $clog2(NPIX);
  localparam logic [CW-1:0] LAST = CW'(NPIX - 1);
  localparam logic [31:0]   STEP = 32'(BYTES_PER_WORD);

  state_t              state;
  state_t              state_nx;
  logic [31:0]         adr_q;
  logic [CW-1:0]       cnt_q;
  logic                rewind_q;
  logic                done;
  logic                advance;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;
  logic [FIFO_W-1:0]   push_word;
  logic [FIFO_W-1:0]   head;
  logic                unused_hi;

  assign done    = wshb.ack | wshb.err | wshb.rty;
  assign advance = (state == READ) && (wshb.ack || wshb.err);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (frame_en && !fifo_full) state_nx = READ;
      READ: if (done) state_nx = IDLE;
    endcase
  end

  // rewind_q remembers any frame_en low period until
  // the FSM is back in IDLE and can restart the frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      adr_q    <= BASE_ADR;
      cnt_q    <= '0;
      rewind_q <= 1'b0;
    end else begin
      state    <= state_nx;
      rewind_q <= !frame_en ||
                  (rewind_q && state != IDLE);
      if (state == IDLE && rewind_q) begin
        adr_q <= BASE_ADR;
        cnt_q <= '0;
      end else if (advance) begin
        if (cnt_q == LAST) begin
          adr_q <= BASE_ADR;
          cnt_q <= '0;
        end else begin
          adr_q <= adr_q + STEP;
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  assign wshb.cyc    = (state == READ);
  assign wshb.stb    = (state == READ);
  assign wshb.we     = 1'b0;
  assign wshb.adr    = adr_q;
  assign wshb.sel    = 4'hF;
  assign wshb.cti    = 3'd0;
  assign wshb.bte    = 2'd0;
  assign wshb.dat_ms = 32'd0;
  assign unused_hi   = ^wshb.dat_sm[31:24];

  assign push_word = {
    (cnt_q == '0),
    wshb.ack ? wshb.dat_sm[23:0] : 24'h000000
  };

  sync_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (advance),
    .din   (push_word),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pix_valid = !fifo_empty;
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = head[23:0];
  assign pix_sof   = head[24] && !fifo_empty;

endmodule

// File: tb/tb_wshb_frame_reader.sv
// Bench for wshb_frame_reader: randomized Wishbone slave,
// frame-walk reference model and pixel scoreboard.
module tb_wshb_frame_reader;
  import wshb_frame_reader_pkg::*;

  localparam logic [31:0] BASE = 32'h100;
  localparam int HD = 4;
  localparam int VD = 2;
  localparam int NW = HD * VD;

  logic   sys_clk = 1'b0;
  logic   sys_rst;
  logic   frame_en;
  logic   pix_ready;
  pixel_t pix_data;
  logic   pix_valid;
  logic   pix_sof;

  wshb_frame_reader_if wb();

  wshb_frame_reader #(
    .BASE_ADR   (BASE),
    .HDISP      (HD),
    .VDISP      (VD),
    .FIFO_DEPTH (8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .frame_en  (frame_en),
    .wshb      (wb),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_sof   (pix_sof)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;

  // reference model: word index within the frame
  logic [24:0] exp_q[$];
  int          k = 0;
  bit          restart = 0;
  bit          req_open = 0;
  logic [31:0] open_adr;
  int          nreq = 0;

  int mode = 0;
  int ready_mode = 0;
  bit arm108 = 0;
  int rty108 = 0;
  int n108 = 0;
  bit arm104 = 0;
  bit stall10c = 0;
  bit saw10c = 0;
  bit stall110 = 0;
  bit saw110 = 0;

  logic [31:0] sl_d;
  int          sl_r;
  int          sl_resp;
  logic [24:0] mon_e;
  logic [24:0] held;
  bit          stall_seen = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, expv);
    end
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Wishbone slave + model update, all on the falling edge
  initial begin
    wb.ack = 0; wb.err = 0; wb.rty = 0; wb.dat_sm = 0;
    forever begin
      @(negedge sys_clk);
      wb.ack = 0; wb.err = 0; wb.rty = 0;
      if (!sys_rst && wb.cyc && wb.stb) begin
        if (!req_open) begin
          req_open = 1;
          open_adr = wb.adr;
          nreq++;
          if (restart) begin
            k = 0;
            restart = 0;
          end
          chk("adr", wb.adr, BASE + 32'(4 * k));
          if (arm108 && wb.adr == 32'h108) n108++;
        end else begin
          chk("adr_hold", wb.adr, open_adr);
        end
        if (stall10c && wb.adr == 32'h10C) begin
          saw10c = 1;
        end else if (stall110 && wb.adr == 32'h110) begin
          saw110 = 1;
        end else begin
          sl_d = $urandom;
          sl_r = $urandom_range(0, 9);
          sl_resp = 0;
          if (mode == 1 && sl_r == 0) sl_resp = 1;
          if (mode == 1 && sl_r == 1) sl_resp = 2;
          if (arm108 && wb.adr == 32'h108) begin
            if (rty108 > 0) begin
              sl_resp = 2;
              rty108--;
            end else begin
              sl_resp = 0;
              arm108 = 0;
            end
          end
          if (arm104 && wb.adr == 32'h104) begin
            sl_resp = 1;
            arm104 = 0;
          end
          wb.dat_sm = sl_d;
          req_open = 0;
          case (sl_resp)
            0: begin
              wb.ack = 1;
              exp_q.push_back({k == 0, sl_d[23:0]});
              k = (k + 1) % NW;
            end
            1: begin
              wb.err = 1;
              exp_q.push_back({k == 0, 24'h000000});
              k = (k + 1) % NW;
            end
            default: wb.rty = 1;
          endcase
        end
      end
    end
  end

  // pixel-side consumer pacing
  initial begin
    pix_ready = 1;
    forever begin
      @(posedge sys_clk);
      #1;
      case (ready_mode)
        0:       pix_ready = 1;
        1:       pix_ready = 0;
        default: pix_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard monitor
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      if (stall_seen && pix_valid)
        chk("stable", {pix_sof, pix_data}, held);
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pixel: got %h want none",
                   {pix_sof, pix_data});
        end else begin
          mon_e = exp_q.pop_front();
          chk("pixel", {pix_sof, pix_data}, mon_e);
        end
      end
      stall_seen = pix_valid && !pix_ready;
      held = {pix_sof, pix_data};
    end else begin
      stall_seen = 0;
    end
  end

  int cyc_hi;
  int nreq0;

  initial begin
    sys_rst = 1;
    frame_en = 0;
    run(3);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stb", wb.stb, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_sof", pix_sof, 0);
    chk("rst_adr", wb.adr, BASE);
    chk("rst_we", wb.we, 0);
    chk("rst_sel", wb.sel, 4'hF);

    sys_rst = 0;
    frame_en = 1;
    run(40);

    ready_mode = 1;
    run(60);
    chk("hold_fill", exp_q.size(), 8);
    chk("hold_valid", pix_valid, 1);
    cyc_hi = 0;
    repeat (20) begin
      @(posedge sys_clk);
      #1;
      if (wb.cyc) cyc_hi++;
    end
    chk("hold_idle", cyc_hi, 0);
    ready_mode = 0;
    run(40);

    n108 = 0;
    rty108 = 2;
    arm108 = 1;
    for (int i = 0; i < 200 && arm108; i++) run(1);
    chk("rty_done", arm108, 0);
    chk("rty_count", n108, 3);
    run(10);

    arm104 = 1;
    for (int i = 0; i < 200 && arm104; i++) run(1);
    chk("err_done", arm104, 0);
    run(10);

    mode = 1;
    ready_mode = 2;
    run(300);
    mode = 0;
    ready_mode = 0;
    run(5);

    saw10c = 0;
    stall10c = 1;
    for (int i = 0; i < 200 && !saw10c; i++) run(1);
    chk("saw_10c", saw10c, 1);
    sys_rst = 1;
    run(1);
    chk("rst_mid_cyc", wb.cyc, 0);
    chk("rst_mid_valid", pix_valid, 0);
    sys_rst = 0;
    exp_q.delete();
    k = 0;
    restart = 0;
    req_open = 0;
    stall10c = 0;
    run(7);

    saw110 = 0;
    stall110 = 1;
    for (int i = 0; i < 200 && !saw110; i++) run(1);
    chk("saw_110", saw110, 1);
    frame_en = 0;
    restart = 1;
    stall110 = 0;
    nreq0 = nreq;
    run(30);
    chk("stop_noreq", nreq, nreq0);
    chk("stop_cyc", wb.cyc, 0);
    frame_en = 1;
    run(20);
    chk("resume", 32'(nreq > nreq0), 1);

    frame_en = 0;
    run(30);
    chk("drain_q", exp_q.size(), 0);
    chk("drain_valid", pix_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
